// File: rtl/cpu_types_pkg.sv
// Shared CPU datapath types: machine word, register index and the
// writeback-queue entry used between execute and the register file.
package cpu_types_pkg;
    typedef logic [31:0] word_t;
    typedef logic [4:0]  regbits_t;

    typedef struct packed {
        regbits_t wsel;
        word_t    wdat;
    } wbq_entry_t;
endpackage

// File: rtl/wb_write_queue_if.sv
// Handshake bundle for the writeback queue: enqueue side, register-file
// drain port and the two decode-stage forwarding lookups.
interface wb_write_queue_if #(
    parameter int DEPTH = 4
);
    import cpu_types_pkg::*;

    localparam int CW = $clog2(DEPTH + 1);

    logic          enq_valid;
    logic          enq_ready;
    regbits_t      enq_wsel;
    word_t         enq_wdat;
    logic          drain_en;
    logic          rf_WEN;
    regbits_t      rf_wsel;
    word_t         rf_wdat;
    regbits_t      rsel1;
    regbits_t      rsel2;
    logic          fwd_hit1;
    logic          fwd_hit2;
    word_t         fwd_dat1;
    word_t         fwd_dat2;
    logic [CW-1:0] count;
    logic          empty;

    modport master (
        output enq_valid, enq_wsel, enq_wdat, drain_en, rsel1, rsel2,
        input  enq_ready, rf_WEN, rf_wsel, rf_wdat,
        input  fwd_hit1, fwd_hit2, fwd_dat1, fwd_dat2, count, empty
    );

    modport slave (
        input  enq_valid, enq_wsel, enq_wdat, drain_en, rsel1, rsel2,
        output enq_ready, rf_WEN, rf_wsel, rf_wdat,
        output fwd_hit1, fwd_hit2, fwd_dat1, fwd_dat2, count, empty
    );
endinterface

// File: rtl/wb_write_queue_match.sv
// Youngest-match search over the occupied queue slots for one read port.
// Slots are walked oldest to youngest so the last hit wins.
module wbq_match
    import cpu_types_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int PW    = $clog2(DEPTH),
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  wbq_entry_t [DEPTH-1:0] i_entries,
    input  logic [PW-1:0]          i_head,
    input  logic [CW-1:0]          i_count,
    input  regbits_t               i_rsel,
    output logic                   o_hit,
    output word_t                  o_dat
);
    always_comb begin
        o_hit = 1'b0;
        o_dat = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if ((CW'(i) < i_count) && (i_rsel != '0) &&
                (i_entries[i_head + PW'(i)].wsel == i_rsel)) begin
                o_hit = 1'b1;
                o_dat = i_entries[i_head + PW'(i)].wdat;
            end
        end
    end
endmodule

// File: rtl/wb_write_queue.sv
// In-order writeback queue between execute and a single register-file write
// port, with forwarding of the youngest pending value to two read selects.
module wb_write_queue
    import cpu_types_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input logic                clk,
    input logic                nRST,
    wb_write_queue_if.slave    bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    wbq_entry_t [DEPTH-1:0] r_q;
    logic [PW-1:0]          r_head;
    logic [PW-1:0]          r_tail;
    logic [CW-1:0]          r_count;

    logic       w_empty;
    logic       w_accept;
    logic       w_enq;
    logic       w_deq;
    wbq_entry_t w_head_ent;

    assign w_empty    = (r_count == '0);
    assign w_head_ent = r_q[r_head];

    // Writes to r0 complete the handshake but are dropped, never stored.
    assign w_accept = bus.enq_valid && bus.enq_ready;
    assign w_enq    = w_accept && (bus.enq_wsel != '0);
    assign w_deq    = bus.drain_en && !w_empty;

    assign bus.enq_ready = (r_count < CW'(DEPTH));
    assign bus.rf_WEN    = w_deq;
    assign bus.rf_wsel   = w_empty ? '0 : w_head_ent.wsel;
    assign bus.rf_wdat   = w_empty ? '0 : w_head_ent.wdat;
    assign bus.count     = r_count;
    assign bus.empty     = w_empty;

    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            r_q     <= '0;
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_enq) begin
                r_q[r_tail] <= '{wsel: bus.enq_wsel, wdat: bus.enq_wdat};
                r_tail      <= r_tail + 1'b1;
            end
            if (w_deq) begin
                r_head <= r_head + 1'b1;
            end
            case ({w_enq, w_deq})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Lookups see registered state only, so a same-cycle enqueue is invisible
    // and the head being drained this cycle still forwards.
    wbq_match #(.DEPTH(DEPTH), .PW(PW), .CW(CW)) u_match1 (
        .i_entries (r_q),
        .i_head    (r_head),
        .i_count   (r_count),
        .i_rsel    (bus.rsel1),
        .o_hit     (bus.fwd_hit1),
        .o_dat     (bus.fwd_dat1)
    );

    wbq_match #(.DEPTH(DEPTH), .PW(PW), .CW(CW)) u_match2 (
        .i_entries (r_q),
        .i_head    (r_head),
        .i_count   (r_count),
        .i_rsel    (bus.rsel2),
        .o_hit     (bus.fwd_hit2),
        .o_dat     (bus.fwd_dat2)
    );
endmodule
